// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants, FSM state encoding and the byte-merge helper for the
//   memory responder. The state encodings are exported here so that a bench
//   can decode the responder's state by name.
package mem_responder_pkg;

  // Width of one memory beat and of its byte-enable mask.
  localparam int MEM_DATA_BITS  = 128;
  localparam int MEM_MASK_BITS  = MEM_DATA_BITS / 8;

  // A cache line is four beats; the low two beat-address bits select the beat.
  localparam int BEATS_PER_LINE = 4;
  localparam int BEAT_BITS      = 2;

  // Responder FSM states.
  typedef enum logic [1:0] {
    MR_IDLE     = 2'd0,
    MR_RD_WAIT  = 2'd1,
    MR_RD_BURST = 2'd2,
    MR_WR_DATA  = 2'd3
  } mr_state_e;

  // Replace the bytes of old_word selected by mask with the bytes of new_word.
  function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
    input logic [MEM_DATA_BITS-1:0] old_word,
    input logic [MEM_DATA_BITS-1:0] new_word,
    input logic [MEM_MASK_BITS-1:0] mask
  );
    logic [MEM_DATA_BITS-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MEM_MASK_BITS; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_array_bytemask.sv
// mem_array_bytemask
//   Single-port (1RW) array of 128-bit words with a per-byte write mask and a
//   one-cycle synchronous read. Contents have no reset.
// Ports:
//   clk    in   clock
//   en     in   port enable; nothing happens when low
//   we     in   1 = masked write, 0 = read
//   addr   in   word index
//   wdata  in   write data
//   wmask  in   byte enables; bit i covers wdata[8i+7:8i]
//   rdata  out  word read on the previous enabled read cycle (held otherwise)
module mem_array_bytemask
  import mem_responder_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [MEM_DATA_BITS-1:0] wdata,
  input  logic [MEM_MASK_BITS-1:0] wmask,
  output logic [MEM_DATA_BITS-1:0] rdata
);

  logic [MEM_DATA_BITS-1:0] mem_r [DEPTH];
  logic [MEM_DATA_BITS-1:0] rdata_r;

  // Storage port: masked write or registered read, never both in one cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= merge_bytes(mem_r[addr], wdata, wmask);
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Main-memory model on the cache mem_req_*/mem_resp_* interface. Serves
//   4-beat line reads after a programmable latency and single-beat
//   byte-masked writes from an internal mem_array_bytemask.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   mem_req_valid         command valid (only sampled in IDLE)
//   mem_req_ready         high in IDLE (accept) and on the last read beat (done)
//   mem_req_addr          beat address; low two bits ignored for reads
//   mem_req_rw            0 = line read, 1 = beat write
//   mem_req_data_valid    write data valid
//   mem_req_data_ready    high while waiting for write data
//   mem_req_data_bits     write data
//   mem_req_data_mask     write byte enables
//   mem_resp_valid        read beat valid
//   mem_resp_data         read beat data, forced to zero between beats
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LINES  = 1024,
  parameter int READ_LATENCY = 4,
  parameter int ADDR_BITS    = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic [ADDR_BITS-1:0]     mem_req_addr,
  input  logic                     mem_req_rw,
  input  logic                     mem_req_data_valid,
  output logic                     mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  output logic                     mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  localparam int         WORDS    = DEPTH_LINES * BEATS_PER_LINE;
  localparam int         IDX_BITS = $clog2(WORDS);
  // The array read is issued in the last wait cycle, so the wait counter
  // starts one below the latency.
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  mr_state_e                state_r, state_next_s;
  logic [3:0]               lat_cnt_r, lat_cnt_next_s;
  logic [BEAT_BITS-1:0]     beat_r, beat_next_s;
  logic [IDX_BITS-1:0]      addr_r, addr_next_s;

  logic                     arr_en_s;
  logic                     arr_we_s;
  logic [IDX_BITS-1:0]      arr_addr_s;
  logic [MEM_DATA_BITS-1:0] arr_rdata_s;

  // Address bits above the array index wrap around and are intentionally dropped.
  logic                     unused_addr_s;
  assign unused_addr_s = ^mem_req_addr[ADDR_BITS-1:IDX_BITS];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= MR_IDLE;
      lat_cnt_r <= 4'd0;
      beat_r    <= 2'd0;
      addr_r    <= '0;
    end else begin
      state_r   <= state_next_s;
      lat_cnt_r <= lat_cnt_next_s;
      beat_r    <= beat_next_s;
      addr_r    <= addr_next_s;
    end
  end

  // Next-state logic and array port control.
  always_comb begin
    state_next_s   = state_r;
    lat_cnt_next_s = lat_cnt_r;
    beat_next_s    = beat_r;
    addr_next_s    = addr_r;
    arr_en_s       = 1'b0;
    arr_we_s       = 1'b0;
    arr_addr_s     = addr_r;

    case (state_r)
      MR_IDLE: begin
        if (mem_req_valid) begin
          addr_next_s = mem_req_addr[IDX_BITS-1:0];
          beat_next_s = 2'd0;
          if (mem_req_rw) begin
            state_next_s = MR_WR_DATA;
          end else begin
            state_next_s   = MR_RD_WAIT;
            lat_cnt_next_s = LAT_INIT;
          end
        end else begin
          state_next_s = MR_IDLE;
        end
      end

      MR_RD_WAIT: begin
        if (lat_cnt_r == 4'd0) begin
          // Fetch beat 0 now so it is on the array output when the burst starts.
          state_next_s = MR_RD_BURST;
          beat_next_s  = 2'd0;
          arr_en_s     = 1'b1;
          arr_addr_s   = {addr_r[IDX_BITS-1:BEAT_BITS], 2'd0};
        end else begin
          lat_cnt_next_s = lat_cnt_r - 4'd1;
        end
      end

      MR_RD_BURST: begin
        if (beat_r == 2'd3) begin
          state_next_s = MR_IDLE;
          beat_next_s  = 2'd0;
        end else begin
          // Prefetch the following beat one cycle ahead.
          beat_next_s = beat_r + 2'd1;
          arr_en_s    = 1'b1;
          arr_addr_s  = {addr_r[IDX_BITS-1:BEAT_BITS], beat_r + 2'd1};
        end
      end

      MR_WR_DATA: begin
        if (mem_req_data_valid) begin
          arr_en_s     = 1'b1;
          arr_we_s     = 1'b1;
          arr_addr_s   = addr_r;
          state_next_s = MR_IDLE;
        end else begin
          state_next_s = MR_WR_DATA;
        end
      end

      default: begin
        state_next_s = MR_IDLE;
      end
    endcase
  end

  // Interface outputs, decoded from registered state only.
  always_comb begin
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;

    case (state_r)
      MR_IDLE: begin
        mem_req_ready = 1'b1;
      end
      MR_RD_WAIT: begin
        mem_req_ready = 1'b0;
      end
      MR_RD_BURST: begin
        // Ready on the last beat is the done marker, not a command accept.
        mem_req_ready  = (beat_r == 2'd3);
        mem_resp_valid = 1'b1;
        mem_resp_data  = arr_rdata_s;
      end
      MR_WR_DATA: begin
        mem_req_data_ready = 1'b1;
      end
      default: begin
        mem_req_ready = 1'b0;
      end
    endcase
  end

  // A write handshake coinciding with reset must not reach the array.
  mem_array_bytemask #(
    .DEPTH  (WORDS),
    .ADDR_W (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .en    (arr_en_s & ~reset),
    .we    (arr_we_s & ~reset),
    .addr  (arr_addr_s),
    .wdata (mem_req_data_bits),
    .wmask (mem_req_data_mask),
    .rdata (arr_rdata_s)
  );

endmodule
